// File: rtl/uart_rx_framed_if.sv
// Receiver-side bundle for uart_rx_framed: the serial line in, the byte/status pulses out.
// UART_RX_PARITY_EN adds the rx_parity_err pulse for 8E1 framing.
interface uart_rx_framed_if;
  logic       rx_in;
  logic       rx_dv;
  logic [7:0] rx_out;
  logic       rx_frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  // master is the receiver itself; slave is the line driver / byte consumer.
  modport master (
    input  rx_in,
`ifdef UART_RX_PARITY_EN
    output rx_parity_err,
`endif
    output rx_dv, rx_out, rx_frame_err, rx_busy
  );

  modport slave (
    output rx_in,
`ifdef UART_RX_PARITY_EN
    input  rx_parity_err,
`endif
    input  rx_dv, rx_out, rx_frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver with input sync, start-glitch rejection, stop-bit check and break hold.
// Define UART_RX_PARITY_EN for 8E1 framing with a registered rx_parity_err pulse.
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_rx_framed_if.master  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  // NOTE: shreg (and par_bad) are pure datapath, fully rewritten before use in every frame, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      sync1            <= 1'b1;
      rx_s             <= 1'b1;
      cnt              <= '0;
      idx              <= '0;
      bus.rx_dv        <= 1'b0;
      bus.rx_out       <= 8'h00;
      bus.rx_frame_err <= 1'b0;
      bus.rx_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.rx_parity_err <= 1'b0;
`endif
    end else begin
      sync1 <= bus.rx_in;
      rx_s  <= sync1;

      // NOTE: pulse outputs default low every cycle, so any set below lasts exactly one cycle.
      bus.rx_dv        <= 1'b0;
      bus.rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.rx_parity_err <= 1'b0;
`endif
      bus.rx_busy <= (state != S_IDLE);
      cnt         <= (cnt == LAST) ? '0 : cnt + 1'b1;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end

        S_START: begin
          if (cnt == MID) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end
        end

        S_DATA: begin
          if (cnt == LAST) begin
            shreg[idx] <= rx_s;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == LAST) begin
            par_bad <= ^{shreg, rx_s};
            state   <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (cnt == LAST) begin
            if (rx_s) begin
              state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                bus.rx_parity_err <= 1'b1;
              end else begin
                bus.rx_dv  <= 1'b1;
                bus.rx_out <= shreg;
              end
`else
              bus.rx_dv  <= 1'b1;
              bus.rx_out <= shreg;
`endif
            end else begin
              // Framing error wins over a parity error on the same frame.
              bus.rx_frame_err <= 1'b1;
              state            <= S_BREAK;
            end
          end
        end

        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench for uart_rx_framed: directed table, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_framed;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;
  localparam int LAT       = 2 + 1 + (CPB - 1) / 2 + (NBITS - 1) * CPB;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_framed_if bus ();

  uart_rx_framed #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Event monitor, sampled on the falling edge.
  logic [7:0] dv_data_q[$];
  int         dv_cyc_q[$];
  logic       dv_busy_q[$];
  logic       post_busy_q[$];
  int         fe_cyc_q[$];
  int         overlap = 0;
  logic       post_dv = 1'b0;

  always @(negedge clk) begin
    if (post_dv) post_busy_q.push_back(bus.rx_busy);
    post_dv = (bus.rx_dv === 1'b1);
    if (bus.rx_dv === 1'b1) begin
      dv_data_q.push_back(bus.rx_out);
      dv_cyc_q.push_back(cyc);
      dv_busy_q.push_back(bus.rx_busy);
    end
    if (bus.rx_frame_err === 1'b1) fe_cyc_q.push_back(cyc);
    if (bus.rx_dv === 1'b1 && bus.rx_frame_err === 1'b1) overlap++;
  end

  task automatic clear_mon();
    dv_data_q.delete();
    dv_cyc_q.delete();
    dv_busy_q.delete();
    post_busy_q.delete();
    fe_cyc_q.delete();
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_range(string name, int got, int lo, int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b);
    bus.rx_in = b;
    tick(CPB);
  endtask

  // Leaves the line at the stop-bit level on return.
  task automatic send_frame(logic [7:0] d, logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         gap;
    int         exp_dv;
    logic [7:0] exp_out;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  int         exp_fe_cnt;
  int         c0;

  initial begin
    vecs[0] = '{8'h31, 1'b1,  0, 20, 1, 8'h31, 0};
    vecs[1] = '{8'hA5, 1'b0, 40, 20, 0, 8'h31, 1};
    vecs[2] = '{8'h0D, 1'b1,  0, 20, 1, 8'h0D, 0};
    vecs[3] = '{8'h00, 1'b1,  0,  5, 1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b1,  0,  0, 1, 8'hFF, 0};
    vecs[5] = '{8'h80, 1'b0,  3, 10, 0, 8'hFF, 1};
    vecs[6] = '{8'h01, 1'b1,  0, 20, 1, 8'h01, 0};

    // Reset with line idle.
    rst_n = 1'b0;
    bus.rx_in = 1'b1;
    tick(3);
    check("rst_dv", bus.rx_dv, 1'b0);
    check("rst_fe", bus.rx_frame_err, 1'b0);
    check("rst_busy", bus.rx_busy, 1'b0);
    check("rst_out", bus.rx_out, 8'h00);
    rst_n = 1'b1;
    clear_mon();
    tick(100);
    check("idle_no_dv", dv_data_q.size(), 0);

    // Single frame: pulse width, latency, busy release.
    clear_mon();
    c0 = cyc;
    send_frame(8'h31, 1'b1);
    tick(20);
    check("f31_count", dv_data_q.size(), 1);
    check("f31_fe", fe_cyc_q.size(), 0);
    if (dv_data_q.size() > 0) begin
      check("f31_data", dv_data_q[0], 8'h31);
      check_range("f31_latency", dv_cyc_q[0] - c0, LAT - 1, LAT + 1);
      check("f31_busy_at_pulse", dv_busy_q[0], 1'b1);
    end
    if (post_busy_q.size() > 0) check("f31_busy_after", post_busy_q[0], 1'b0);

    // Start-bit glitch.
    clear_mon();
    bus.rx_in = 1'b0;
    tick(5);
    bus.rx_in = 1'b1;
    tick(40);
    check("glitch_dv", dv_data_q.size(), 0);
    check("glitch_fe", fe_cyc_q.size(), 0);
    check("glitch_busy", bus.rx_busy, 1'b0);
    send_frame(8'h30, 1'b1);
    tick(20);
    check("post_glitch_out", bus.rx_out, 8'h30);
    check("post_glitch_count", dv_data_q.size(), 1);

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      send_frame(vecs[v].data, vecs[v].stop);
      tick(vecs[v].hold);
      if (!vecs[v].stop) check($sformatf("v%0d_busy_break", v), bus.rx_busy, 1'b1);
      bus.rx_in = 1'b1;
      tick(vecs[v].gap + 6);
      check($sformatf("v%0d_dv_count", v), dv_data_q.size(), vecs[v].exp_dv);
      check($sformatf("v%0d_fe_count", v), fe_cyc_q.size(), vecs[v].exp_fe);
      check($sformatf("v%0d_out", v), bus.rx_out, vecs[v].exp_out);
      check($sformatf("v%0d_busy_idle", v), bus.rx_busy, 1'b0);
    end

    // Back-to-back frames with no idle gap.
    clear_mon();
    send_frame(8'h30, 1'b1);
    send_frame(8'h31, 1'b1);
    send_frame(8'h31, 1'b1);
    send_frame(8'h30, 1'b1);
    tick(20);
    check("b2b_count", dv_data_q.size(), 4);
    if (dv_data_q.size() == 4) begin
      check("b2b_d0", dv_data_q[0], 8'h30);
      check("b2b_d1", dv_data_q[1], 8'h31);
      check("b2b_d2", dv_data_q[2], 8'h31);
      check("b2b_d3", dv_data_q[3], 8'h30);
      for (int i = 1; i < 4; i++)
        check_range($sformatf("b2b_gap%0d", i), dv_cyc_q[i] - dv_cyc_q[i-1], FRAME_CYC - 1, FRAME_CYC + 1);
    end

    // Reset in the middle of a data phase.
    clear_mon();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    tick(2);
    check("midrst_busy", bus.rx_busy, 1'b0);
    check("midrst_out", bus.rx_out, 8'h00);
    rst_n = 1'b1;
    bus.rx_in = 1'b1;
    tick(200);
    check("midrst_no_dv", dv_data_q.size(), 0);
    check("midrst_no_fe", fe_cyc_q.size(), 0);
    send_frame(8'h0A, 1'b1);
    tick(20);
    check("midrst_next", bus.rx_out, 8'h0A);
    check("midrst_next_count", dv_data_q.size(), 1);

    // Randomized frames against a frame-level model.
    clear_mon();
    exp_q.delete();
    last_good = 8'h0A;
    exp_fe_cnt = 0;
    for (int f = 0; f < 24; f++) begin
      logic [7:0] d;
      logic       stop;
      int         hold;
      int         gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      hold = stop ? 0 : int'($urandom_range(0, 30));
      gap  = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
      if (stop) begin
        exp_q.push_back(d);
        last_good = d;
      end else begin
        exp_fe_cnt++;
      end
      send_frame(d, stop);
      tick(hold);
      bus.rx_in = 1'b1;
      tick(gap);
    end
    tick(30);
    check("rnd_dv_count", dv_data_q.size(), exp_q.size());
    check("rnd_fe_count", fe_cyc_q.size(), exp_fe_cnt);
    check("rnd_last_out", bus.rx_out, last_good);
    for (int i = 0; i < exp_q.size() && i < dv_data_q.size(); i++)
      check($sformatf("rnd_byte%0d", i), dv_data_q[i], exp_q[i]);
    for (int i = 1; i < dv_cyc_q.size(); i++)
      check_range($sformatf("rnd_spacing%0d", i), dv_cyc_q[i] - dv_cyc_q[i-1], FRAME_CYC - 1, 1000000);

    check("dv_fe_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
- UART receiver (8N1, LSB first) feeding the operand-capture logic: delivers one received byte per frame as a single-cycle valid pulse plus byte.
- Adds input synchronisation, start-bit glitch rejection, stop-bit framing check and break handling.
- Consumer samples RX_DV / RX_OUT on either clock edge, so both outputs are registered and stable for a full CLK period.

Parameters:
- CLKS_PER_BIT, 5208, CLK cycles per UART bit (50 MHz / 9600 baud); legal range >= 4.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  synchronous active-low reset, sampled on posedge CLK.
- RX_IN  in  1  asynchronous serial line, idle high.
- RX_DV  out  1  one-cycle pulse: RX_OUT holds a new valid byte.
- RX_OUT  out  8  last good byte; holds until the next good frame.
- RX_FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- RX_BUSY  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (RST_N low at a posedge): state = IDLE, bit counter = 0, clock counter = 0, RX_DV = 0, RX_FRAME_ERR = 0, RX_BUSY = 0, RX_OUT = 8'h00, synchroniser flops = 1.
- Reset has priority over everything and aborts any frame in progress with no pulse emitted.
- RX_IN passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
- Clock counter cnt counts 0..CLKS_PER_BIT-1 and is cleared on every state change.
- States:
  - IDLE: RX_BUSY = 0. When rx_s == 0, go to START and clear cnt.
  - START: when cnt == (CLKS_PER_BIT-1)/2 (integer division), sample rx_s.
    - rx_s == 0: go to DATA with bit index = 0.
    - rx_s == 1: glitch; return to IDLE with no pulse.
  - DATA: when cnt == CLKS_PER_BIT-1, shift rx_s into shift register bit [index] (LSB first) and increment index. After index 7 is sampled, go to STOP.
  - STOP: when cnt == CLKS_PER_BIT-1, sample rx_s.
    - rx_s == 1: RX_OUT <= shift register; RX_DV = 1 for exactly one cycle; go to IDLE.
    - rx_s == 0: RX_FRAME_ERR = 1 for exactly one cycle; RX_OUT unchanged; go to BREAK.
  - BREAK: remain until rx_s == 1, then go to IDLE. No bytes are produced while the line is held low.
- RX_BUSY = 1 in START, DATA, STOP and BREAK.
- Latency: RX_DV rises on the posedge after the stop-bit sample. From the RX_IN falling edge to RX_DV the delay is 2 (sync) + 1 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles, ±1.
- Back-to-back frames: a start edge arriving on the cycle right after RX_DV is accepted. No idle gap beyond the stop bit is required.
- RX_DV and RX_FRAME_ERR are never high in the same cycle.
- No backpressure: a byte not taken within its pulse cycle is overwritten only by the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a PARITY state sits between DATA and STOP and samples at cnt == CLKS_PER_BIT-1.
  - Extra output RX_PARITY_ERR (1 bit) pulses for one cycle, in place of RX_DV, when the XOR of the data bits and the parity bit is 1. RX_OUT is not updated in that case.
  - A frame with both a parity error and a framing error reports RX_FRAME_ERR only.
- Undefined: PARITY state and RX_PARITY_ERR port do not exist; frame is 8N1 as above.

Test Plan (CLKS_PER_BIT = 16 in simulation):
- RST_N low 3 cycles, RX_IN = 1 -> all outputs 0, RX_OUT = 8'h00. After release, 100 idle cycles -> RX_DV never pulses.
- Send 8'h31 ("1") as 8N1 -> exactly one RX_DV pulse, 1 cycle wide, RX_OUT = 8'h31 at the pulse. RX_FRAME_ERR stays 0. RX_BUSY falls the cycle after the pulse.
- Drive RX_IN low for 5 cycles, then high -> returns to IDLE, no RX_DV, no RX_FRAME_ERR. A following frame 8'h30 decodes to RX_OUT = 8'h30.
- Send 8'hA5 with stop bit = 0, then hold line low 40 cycles -> one RX_FRAME_ERR pulse, RX_OUT keeps its previous value, RX_BUSY stays high until the line returns high. A next frame 8'h0D is received correctly.
- Send frames 8'h30, 8'h31, 8'h31, 8'h30 back-to-back with no idle gap -> four RX_DV pulses, spaced 160 ±1 cycles, with RX_OUT equal to each byte in order.
- Assert RST_N low mid-DATA of frame 8'hFF -> no pulse emitted, state IDLE. A subsequent frame 8'h0A is received as 8'h0A.
